// File: rtl/geofence_pkg.sv
// Shared constants, FSM state type and round-robin winner search for the geofence sqrt arbiter.
package geofence_pkg;

  localparam int unsigned NREQ_DEF  = 4;
  localparam int unsigned IN_W_DEF  = 29;
  localparam int unsigned OUT_W_DEF = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Search ptr+1, ptr+2, ... modulo n; descending loop so the nearest set bit wins.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  win;
    int unsigned idx;
    win = ptr;
    for (int unsigned i = n; i >= 1; i--) begin
      idx = (32'(ptr) + i) % n;
      if (req[idx[2:0]]) win = idx[2:0];
    end
    return win;
  endfunction

endpackage

// File: rtl/geofence_sqrt_arb_if.sv
// Requester-side bus of the shared square-root engine: request/operand in, grant/result out.
interface geofence_sqrt_arb_if import geofence_pkg::*; #(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) ();

  logic [NREQ-1:0]      req;
  logic [NREQ*IN_W-1:0] operand;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rsp_valid;
  logic [OUT_W-1:0]     root;
  logic                 busy;

  modport master (output req, operand, input gnt, rsp_valid, root, busy);
  modport slave  (input req, operand, output gnt, rsp_valid, root, busy);

endinterface

// File: rtl/geofence_sqrt_iter.sv
// Bit-serial restoring integer square root, one root bit per clock, MSB first.
// Round-to-nearest on the final bit when GEOFENCE_SQRT_ROUND_EN is defined.
module geofence_sqrt_iter import geofence_pkg::*; #(
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IN_W-1:0]  radicand,
  output logic             done,
  output logic [OUT_W-1:0] root
);

  localparam int unsigned RAD_W  = 2 * OUT_W;
  localparam int unsigned REM_W  = OUT_W + 1;
  localparam int unsigned CAND_W = OUT_W + 3;
  localparam int unsigned CNT_W  = $clog2(OUT_W + 1);

  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]  root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic [CAND_W-1:0] cand, sub;
  logic              fits;

  always_comb begin
    cand     = {rem_q, rad_q[RAD_W-1 -: 2]};
    sub      = {1'b0, root_q, 2'b01};
    fits     = (cand >= sub);
    rad_d    = rad_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done     = 1'b0;
    if (start) begin
      rad_d    = RAD_W'(radicand);
      rem_d    = '0;
      root_d   = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      rad_d  = rad_q << 2;
      rem_d  = fits ? REM_W'(cand - sub) : REM_W'(cand);
      root_d = {root_q[OUT_W-2:0], fits};
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(OUT_W - 1)) begin
        active_d = 1'b0;
        done     = 1'b1;
      end
    end
    // root is the value the current edge produces, so the caller can register it on done
    root = root_d;
`ifdef GEOFENCE_SQRT_ROUND_EN
    if ((rem_d > REM_W'(root_d)) && (root_d != '1)) root = root_d + OUT_W'(1);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rad_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rad_q    <= rad_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/geofence_sqrt_arb.sv
// Round-robin arbiter sharing one iterative sqrt engine among NREQ requesters.
// Optional round-to-nearest result via GEOFENCE_SQRT_ROUND_EN (applied inside geofence_sqrt_iter).
module geofence_sqrt_arb import geofence_pkg::*; #(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned IN_W  = IN_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  geofence_sqrt_arb_if.slave bus
);

  state_e           state_q, state_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       winner_q, winner_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic             busy_q, busy_d;

  logic             start;
  logic [2:0]       pick;
  logic [IN_W-1:0]  radicand;
  logic             eng_done;
  logic [OUT_W-1:0] eng_root;

  // The engine loads the winner's operand on the accept edge itself, so CALC holds OUT_W edges.
  geofence_sqrt_iter #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .radicand (radicand),
    .done     (eng_done),
    .root     (eng_root)
  );

  always_comb begin
    pick        = rr_next(8'(bus.req), rr_ptr_q, NREQ);
    radicand    = bus.operand[32'(pick) * IN_W +: IN_W];
    start       = (state_q == IDLE) && (bus.req != '0);
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    root_d      = root_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          gnt_d    = NREQ'(1) << pick;
          winner_d = pick;
          rr_ptr_d = pick;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (eng_done) begin
          root_d      = eng_root;
          rsp_valid_d = NREQ'(1) << winner_q;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 3'(NREQ - 1);
      winner_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      root_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      root_q      <= root_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.root      = root_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_geofence_sqrt_arb.sv
// Scoreboard bench for geofence_sqrt_arb: expected roots queued at grant, compared at rsp_valid.
module tb_geofence_sqrt_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned IN_W  = 29;
  localparam int unsigned OUT_W = 15;

  logic clk = 1'b0;
  logic reset;

  geofence_sqrt_arb_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  geofence_sqrt_arb #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [IN_W-1:0] ops [NREQ];

  typedef struct {
    int unsigned      idx;
    logic [OUT_W-1:0] root;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [OUT_W-1:0] ref_root(input logic [IN_W-1:0] x);
    longint unsigned r, t, xv;
    xv = {35'd0, x};
    r  = 0;
    for (int b = OUT_W - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= xv) r = t;
    end
`ifdef GEOFENCE_SQRT_ROUND_EN
    if ((xv - r * r > r) && (r < 64'd32767)) r = r + 1;
`endif
    return r[OUT_W-1:0];
  endfunction

  function automatic int unsigned idx_of(input logic [NREQ-1:0] oh);
    int unsigned k;
    k = 0;
    for (int i = NREQ - 1; i >= 0; i--) if (oh[i]) k = i;
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_ops();
    for (int k = 0; k < NREQ; k++) bus.operand[k*IN_W +: IN_W] = ops[k];
  endtask

  task automatic rand_ops();
    for (int k = 0; k < NREQ; k++) ops[k] = IN_W'($urandom);
    apply_ops();
  endtask

  task automatic wait_gnt(output logic [NREQ-1:0] g, output bit ok);
    ok = 1'b0;
    g  = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.gnt != '0) begin
        g  = bus.gnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output logic [NREQ-1:0] rv, output logic [OUT_W-1:0] r, output bit ok);
    ok = 1'b0;
    rv = '0;
    r  = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.rsp_valid != '0) begin
        rv = bus.rsp_valid;
        r  = bus.root;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    bus.req = '0;
    for (int k = 0; k < NREQ; k++) ops[k] = '0;
    apply_ops();
    step();
    step();
    checks++;
    if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt); end
    checks++;
    if (bus.rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp got=%b want=0000", bus.rsp_valid); end
    checks++;
    if (bus.root !== '0) begin errors++; $display("FAIL reset_root got=%0d want=0", bus.root); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [NREQ-1:0]  g, rv;
    logic [OUT_W-1:0] r;
    bit ok;
    exp_t e;
    ops[2] = 29'd1000000;
    apply_ops();
    bus.req = 4'b0100;
    wait_gnt(g, ok);
    checks++;
    if (!ok || g !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b want=0100", g); end
    exp_q.push_back('{2, 15'd1000});
    bus.req = '0;
    repeat (14) step();
    checks++;
    if (bus.rsp_valid !== '0 || bus.gnt !== '0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_early rsp=%b gnt=%b busy=%b want rsp=0000 gnt=0000 busy=1",
               bus.rsp_valid, bus.gnt, bus.busy);
    end
    step();
    rv = bus.rsp_valid;
    r  = bus.root;
    e  = exp_q.pop_front();
    checks++;
    if (rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
      errors++;
      $display("FAIL single_rsp got rsp=%b root=%0d want rsp=%b root=%0d", rv, r, NREQ'(1) << e.idx, e.root);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== '0) begin
      errors++;
      $display("FAIL single_idle busy=%b rsp=%b want busy=0 rsp=0000", bus.busy, bus.rsp_valid);
    end
    if (!ok) begin
      wait_rsp(rv, r, ok);
    end
  endtask

  task automatic test_boundaries();
    logic [IN_W-1:0]  vals [4];
    logic [OUT_W-1:0] want [4];
    logic [NREQ-1:0]  g, rv;
    logic [OUT_W-1:0] r;
    bit ok;
    exp_t e;
    vals = '{29'd0, 29'd536870911, 29'd8, 29'd2};
`ifdef GEOFENCE_SQRT_ROUND_EN
    want = '{15'd0, 15'd23170, 15'd3, 15'd1};
`else
    want = '{15'd0, 15'd23170, 15'd2, 15'd1};
`endif
    for (int i = 0; i < 4; i++) begin
      ops[0] = vals[i];
      apply_ops();
      bus.req = 4'b0001;
      wait_gnt(g, ok);
      checks++;
      if (!ok || g !== 4'b0001) begin errors++; $display("FAIL bound_gnt[%0d] got=%b want=0001", i, g); end
      exp_q.push_back('{0, want[i]});
      bus.req = '0;
      wait_rsp(rv, r, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
        errors++;
        $display("FAIL bound_root[%0d] op=%0d got rsp=%b root=%0d want rsp=%b root=%0d",
                 i, vals[i], rv, r, NREQ'(1) << e.idx, e.root);
      end
      step();
    end
  endtask

  task automatic test_contention();
    int unsigned     order [8];
    logic [NREQ-1:0] g, rv;
    logic [OUT_W-1:0] r;
    bit ok;
    exp_t e;
    order   = '{0, 1, 2, 3, 0, 1, 3, 1};
    reset   = 1'b1;
    bus.req = 4'b1111;
    rand_ops();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_gnt(g, ok);
      checks++;
      if (!ok || g !== (NREQ'(1) << order[i])) begin
        errors++;
        $display("FAIL contend_gnt[%0d] got=%b want=%b", i, g, NREQ'(1) << order[i]);
      end
      exp_q.push_back('{idx_of(g), ref_root(ops[idx_of(g)])});
      if (i == 7) bus.req = '0;
      wait_rsp(rv, r, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
        errors++;
        $display("FAIL contend_rsp[%0d] got rsp=%b root=%0d want rsp=%b root=%0d",
                 i, rv, r, NREQ'(1) << e.idx, e.root);
      end
      rand_ops();
      if (i == 4) bus.req = 4'b1010;
    end
    step();
  endtask

  task automatic test_fairness();
    int unsigned      cnt [NREQ];
    int unsigned      last, want_idx, min_cnt;
    logic [NREQ-1:0]  g, rv;
    logic [OUT_W-1:0] r;
    bit ok;
    exp_t e;
    for (int k = 0; k < NREQ; k++) cnt[k] = 0;
    rand_ops();
    bus.req = 4'b1000;
    wait_gnt(g, ok);
    checks++;
    if (!ok || g !== 4'b1000) begin errors++; $display("FAIL fair_pre got=%b want=1000", g); end
    exp_q.push_back('{idx_of(g), ref_root(ops[idx_of(g)])});
    bus.req = '0;
    wait_rsp(rv, r, ok);
    e = exp_q.pop_front();
    rand_ops();
    bus.req = 4'b1001;
    last    = 3;
    for (int i = 0; i < 20; i++) begin
      want_idx = (i < 4) ? ((i % 2 == 0) ? 0 : 3) : (last + 1) % NREQ;
      wait_gnt(g, ok);
      checks++;
      if (!ok || g !== (NREQ'(1) << want_idx)) begin
        errors++;
        $display("FAIL fair_gnt[%0d] got=%b want=%b", i, g, NREQ'(1) << want_idx);
      end
      last = idx_of(g);
      cnt[last]++;
      exp_q.push_back('{last, ref_root(ops[last])});
      if (i == 19) bus.req = '0;
      wait_rsp(rv, r, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
        errors++;
        $display("FAIL fair_rsp[%0d] got rsp=%b root=%0d want rsp=%b root=%0d",
                 i, rv, r, NREQ'(1) << e.idx, e.root);
      end
      rand_ops();
      if (i == 3) bus.req = 4'b1111;
    end
    min_cnt = cnt[0];
    for (int k = 1; k < NREQ; k++) if (cnt[k] < min_cnt) min_cnt = cnt[k];
    checks++;
    if (min_cnt < 4) begin errors++; $display("FAIL fair_starve min_grants=%0d want>=4", min_cnt); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0]  g, rv;
    logic [OUT_W-1:0] r;
    bit ok, seen;
    exp_t e;
    rand_ops();
    bus.req = 4'b0100;
    wait_gnt(g, ok);
    checks++;
    if (!ok || g !== 4'b0100) begin errors++; $display("FAIL midrst_gnt got=%b want=0100", g); end
    exp_q.push_back('{2, ref_root(ops[2])});
    bus.req = '0;
    repeat (4) step();
    reset = 1'b1;
    exp_q.delete();
    step();
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rsp_valid != '0 || bus.busy != 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midrst_quiet got activity=1 want activity=0"); end
    bus.req = 4'b1111;
    wait_gnt(g, ok);
    checks++;
    if (!ok || g !== 4'b0001) begin errors++; $display("FAIL midrst_regnt got=%b want=0001", g); end
    exp_q.push_back('{idx_of(g), ref_root(ops[idx_of(g)])});
    bus.req = '0;
    wait_rsp(rv, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
      errors++;
      $display("FAIL midrst_rsp got rsp=%b root=%0d want rsp=%b root=%0d", rv, r, NREQ'(1) << e.idx, e.root);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [NREQ-1:0]  g, rv;
    logic [OUT_W-1:0] r;
    int unsigned      t0;
    bit ok;
    exp_t e;
    rand_ops();
    bus.req = 4'b0010;
    wait_gnt(g, ok);
    t0 = cyc;
    checks++;
    if (!ok || g !== 4'b0010) begin errors++; $display("FAIL b2b_gnt1 got=%b want=0010", g); end
    exp_q.push_back('{1, ref_root(ops[1])});
    wait_rsp(rv, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
      errors++;
      $display("FAIL b2b_rsp1 got rsp=%b root=%0d want rsp=%b root=%0d", rv, r, NREQ'(1) << e.idx, e.root);
    end
    rand_ops();
    wait_gnt(g, ok);
    checks++;
    if (!ok || g !== 4'b0010 || (cyc - t0) != 17) begin
      errors++;
      $display("FAIL b2b_gnt2 got gnt=%b gap=%0d want gnt=0010 gap=17", g, cyc - t0);
    end
    exp_q.push_back('{1, ref_root(ops[1])});
    bus.req = '0;
    wait_rsp(rv, r, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || rv !== (NREQ'(1) << e.idx) || r !== e.root) begin
      errors++;
      $display("FAIL b2b_rsp2 got rsp=%b root=%0d want rsp=%b root=%0d", rv, r, NREQ'(1) << e.idx, e.root);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d want=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
